cgra_power_sequencer: RTL and testbench
=======================================

# cgra_power_sequencer

Power-sequencing controller for the CGRA external subsystem domain. It turns single-cycle on/off requests into the ordered isolation, reset, clock-gate, power-switch and RAM-retention control that the MCU exposes for external subsystems. It sits between the always-on control logic and the CGRA wrapper's reset, clock-enable and retention inputs. It also handles the power-switch acknowledge handshake, with a timeout.

## Interface
- ISO_WAIT, default 4: cycles between asserting isolation and asserting reset (1..255).
- RST_WAIT, default 4: cycles reset is held after the clock is ungated, on power-up and after system reset (1..255).
- ACK_TIMEOUT, default 255: maximum cycles to wait for the switch ack (1..65535).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- on_req_i  in  1  single-cycle power-up request.
- off_req_i  in  1  single-cycle power-down request.
- retentive_req_i  in  1  sampled with off_req_i; keeps CGRA memories retentive while off.
- cgra_idle_i  in  1  high when the CGRA is not executing.
- switch_ack_ni  in  1  power-switch status; 0 = domain powered.
- clkgate_en_no  out  1  0 = CGRA clock running.
- switch_no  out  1  0 = switch closed (power on).
- iso_no  out  1  0 = outputs isolated.
- subsys_rst_no  out  1  0 = CGRA logic in reset.
- ram_retentive_no  out  1  0 = memory banks retentive.
- busy_o  out  1  a sequence is in progress.
- done_o  out  1  one-cycle pulse when a sequence ends, including on timeout.
- is_on_o  out  1  state is ON.
- error_o  out  1  sticky ack-timeout flag.

## Operation
- FSM states: BOOT_RST, ON, OFF_IDLE, OFF_ISO, OFF_SW, OFF_ACK, OFF, ON_SW, ON_ACK, ON_RST, ON_ISO.
- Request acceptance:
  - off_req_i is accepted only in ON; on_req_i only in OFF.
  - Requests in any other state are dropped, with no queueing.
  - If both are high, only the one legal for the current state is accepted.
  - Accepting a request clears error_o.
- Power-down sequence:
  - ON -> OFF_IDLE: latch retentive_req_i.
  - OFF_IDLE: wait for cgra_idle_i = 1, with no timeout.
  - -> OFF_ISO: iso_no = 0; count ISO_WAIT cycles.
  - -> OFF_SW: in the same cycle, subsys_rst_no = 0, clkgate_en_no = 1, switch_no = 1, and ram_retentive_no = !latched_retentive.
  - -> OFF_ACK: wait for switch_ack_ni = 1, then go to OFF.
- Power-up sequence:
  - OFF -> ON_SW: switch_no = 0.
  - -> ON_ACK: wait for switch_ack_ni = 0.
  - -> ON_RST: ram_retentive_no = 1 and clkgate_en_no = 0; reset stays asserted for RST_WAIT cycles.
  - -> ON_ISO: subsys_rst_no = 1 for one cycle, with isolation still active.
  - -> ON: iso_no = 1.
- Timeout:
  - In OFF_ACK or ON_ACK, a wait counter starts at 0 on entry.
  - If the counter reaches ACK_TIMEOUT-1 without the expected ack level, set error_o and pulse done_o.
  - An OFF_ACK timeout goes to OFF.
  - An ON_ACK timeout reopens the switch (switch_no = 1) and goes to OFF.
- done_o pulses in the cycle the FSM enters ON or OFF from a sequence.
- busy_o is high in every state except ON and OFF.
- is_on_o = (state == ON).

## Timing
- Reset values while rst_ni = 0:
  - state BOOT_RST, counters 0.
  - subsys_rst_no = 0, iso_no = 0.
  - clkgate_en_no = 0, switch_no = 0.
  - ram_retentive_no = 1.
  - busy_o = 1, done_o = 0, is_on_o = 0, error_o = 0.
- BOOT_RST holds for RST_WAIT cycles after rst_ni rises, then goes to ON_ISO, then ON. ON is reached RST_WAIT+1 cycles after reset release, and done_o pulses on entry.
- All outputs are registered; a state change is visible on the outputs in the cycle after the transition edge.
- Off latency with an idle CGRA and an immediate ack: 1 (OFF_IDLE) + ISO_WAIT + 1 (OFF_SW) + 1 (OFF_ACK) cycles.
- On latency with an immediate ack: 1 + 1 + RST_WAIT + 1 cycles.
- switch_ack_ni is used directly as a synchronous input; any synchronization belongs to the caller.
- Counters are $clog2(max_param + 1) bits wide, never wrap, and reset to 0 on each state entry.
- A reset asserted mid-sequence returns the block immediately (asynchronously) to reset values. A latched retention request is lost.

## Structure
- A shared package cgra_x_heep_pkg holds:
  - typedef enum logic [3:0] cgra_pwr_state_e;
  - the localparam defaults CGRA_PWR_ISO_WAIT, CGRA_PWR_RST_WAIT and CGRA_PWR_ACK_TIMEOUT.
- One sub-module, cgra_pwr_wait_cnt: a loadable down-counter with load_i, len_i and expired_o. It is instantiated once and shared by all wait states.
- The FSM and output registers sit in the top module.

## Test plan
- Reset release with defaults:
  - subsys_rst_no stays 0 for 4 cycles, then becomes 1.
  - iso_no rises 1 cycle later.
  - is_on_o = 1 and done_o pulses once.
- off_req_i with cgra_idle_i = 0 for 10 cycles, then 1, and ack following switch_no after 3 cycles:
  - iso_no falls 1 cycle after idle.
  - rst, clk-gate and switch assert 4 cycles later.
  - OFF is reached 3 cycles after that.
- off_req_i with retentive_req_i = 1:
  - ram_retentive_no = 0 throughout OFF.
  - After on_req_i it returns to 1 in the cycle clkgate_en_no falls.
- on_req_i with switch_ack_ni stuck at 1 and ACK_TIMEOUT = 8:
  - error_o sets after 8 cycles in ON_ACK.
  - switch_no returns to 1; state OFF; done_o pulses.
  - The next on_req_i clears error_o.
- Illegal requests: on_req_i in ON and off_req_i during OFF_ISO leave the state and outputs unchanged. on_req_i and off_req_i together in ON start the power-down.
- rst_ni pulsed low during ON_RST: all outputs return to reset values asynchronously, then the boot sequence repeats.

Source files
------------

// File: rtl/cgra_x_heep_pkg.sv
// Shared types and defaults for the CGRA power-domain sequencer.
package cgra_x_heep_pkg;

    localparam int unsigned CGRA_PWR_ISO_WAIT    = 32'd4;
    localparam int unsigned CGRA_PWR_RST_WAIT    = 32'd4;
    localparam int unsigned CGRA_PWR_ACK_TIMEOUT = 32'd255;

    typedef enum logic [3:0] {
        BOOT_RST = 4'd0,
        ON       = 4'd1,
        OFF_IDLE = 4'd2,
        OFF_ISO  = 4'd3,
        OFF_SW   = 4'd4,
        OFF_ACK  = 4'd5,
        OFF      = 4'd6,
        ON_SW    = 4'd7,
        ON_ACK   = 4'd8,
        ON_RST   = 4'd9,
        ON_ISO   = 4'd10
    } cgra_pwr_state_e;

    function automatic int unsigned cgra_pwr_max3(input int unsigned a,
                                                  input int unsigned b,
                                                  input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cgra_pwr_wait_cnt.sv
// Shared wait counter: load_i restarts it at 0; expired_o rises once len_i
// cycles have been spent since the load, and the count then holds.
module cgra_pwr_wait_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] len_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q >= (len_i - W'(1)));

    // Next count: restart on load, saturate once expired.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (!expired_o) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cgra_power_sequencer.sv
// Power sequencer for the CGRA domain: orders isolation, reset, clock gate,
// power switch and RAM retention around single-cycle on/off requests.
module cgra_power_sequencer
    import cgra_x_heep_pkg::*;
#(
    parameter int unsigned ISO_WAIT    = CGRA_PWR_ISO_WAIT,
    parameter int unsigned RST_WAIT    = CGRA_PWR_RST_WAIT,
    parameter int unsigned ACK_TIMEOUT = CGRA_PWR_ACK_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic on_req_i,
    input  logic off_req_i,
    input  logic retentive_req_i,
    input  logic cgra_idle_i,
    input  logic switch_ack_ni,
    output logic clkgate_en_no,
    output logic switch_no,
    output logic iso_no,
    output logic subsys_rst_no,
    output logic ram_retentive_no,
    output logic busy_o,
    output logic done_o,
    output logic is_on_o,
    output logic error_o
);

    localparam int unsigned MAX_WAIT = cgra_pwr_max3(ISO_WAIT, RST_WAIT, ACK_TIMEOUT);
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 32'd1);
    localparam logic [CNT_W-1:0] ISO_LEN = CNT_W'(ISO_WAIT);
    localparam logic [CNT_W-1:0] RST_LEN = CNT_W'(RST_WAIT);
    localparam logic [CNT_W-1:0] ACK_LEN = CNT_W'(ACK_TIMEOUT);

    cgra_pwr_state_e state_q, state_d;
    logic ret_q, ret_d;
    logic err_q, err_d;
    logic clkgate_q, clkgate_d, switch_q, switch_d, iso_q, iso_d;
    logic rst_q, rst_d, ram_q, ram_d;
    logic busy_q, busy_d, done_q, done_d, on_q, on_d;
    logic             cnt_load_s, cnt_expired_s;
    logic [CNT_W-1:0] cnt_len_s;

    // Every state entry restarts the shared counter with that state's length.
    assign cnt_load_s = (state_d != state_q);

    // Wait length of the current state.
    always_comb begin
        cnt_len_s = CNT_W'(1);
        case (state_q)
            BOOT_RST, ON_RST: cnt_len_s = RST_LEN;
            OFF_ISO:          cnt_len_s = ISO_LEN;
            OFF_ACK, ON_ACK:  cnt_len_s = ACK_LEN;
            default:          cnt_len_s = CNT_W'(1);
        endcase
    end

    cgra_pwr_wait_cnt #(
        .W(CNT_W)
    ) u_wait_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (cnt_load_s),
        .len_i    (cnt_len_s),
        .expired_o(cnt_expired_s)
    );

    // Next-state logic, request acceptance, retention latch and error flag.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        err_d   = err_q;
        case (state_q)
            BOOT_RST: if (cnt_expired_s) state_d = ON_ISO; else state_d = BOOT_RST;
            ON: begin
                if (off_req_i) begin
                    state_d = OFF_IDLE;
                    ret_d   = retentive_req_i;
                    err_d   = 1'b0;
                end else begin
                    state_d = ON;
                end
            end
            OFF_IDLE: if (cgra_idle_i) state_d = OFF_ISO; else state_d = OFF_IDLE;
            OFF_ISO:  if (cnt_expired_s) state_d = OFF_SW; else state_d = OFF_ISO;
            OFF_SW:   state_d = OFF_ACK;
            OFF_ACK: begin
                if (switch_ack_ni) begin
                    state_d = OFF;
                end else if (cnt_expired_s) begin
                    state_d = OFF;
                    err_d   = 1'b1;
                end else begin
                    state_d = OFF_ACK;
                end
            end
            OFF: begin
                if (on_req_i) begin
                    state_d = ON_SW;
                    err_d   = 1'b0;
                end else begin
                    state_d = OFF;
                end
            end
            ON_SW: state_d = ON_ACK;
            ON_ACK: begin
                // A timeout lands in OFF, whose outputs reopen the switch.
                if (!switch_ack_ni) begin
                    state_d = ON_RST;
                end else if (cnt_expired_s) begin
                    state_d = OFF;
                    err_d   = 1'b1;
                end else begin
                    state_d = ON_ACK;
                end
            end
            ON_RST:  if (cnt_expired_s) state_d = ON_ISO; else state_d = ON_RST;
            ON_ISO:  state_d = ON;
            default: state_d = BOOT_RST;
        endcase
    end

    // Output values for the state being entered, so they register with it.
    always_comb begin
        clkgate_d = 1'b0;
        switch_d  = 1'b0;
        iso_d     = 1'b0;
        rst_d     = 1'b0;
        ram_d     = 1'b1;
        case (state_d)
            ON, OFF_IDLE: begin
                iso_d = 1'b1;
                rst_d = 1'b1;
            end
            ON_ISO, OFF_ISO: rst_d = 1'b1;
            OFF_SW, OFF_ACK, OFF: begin
                clkgate_d = 1'b1;
                switch_d  = 1'b1;
                ram_d     = !ret_d;
            end
            ON_SW, ON_ACK: begin
                clkgate_d = 1'b1;
                ram_d     = !ret_d;
            end
            default: ram_d = 1'b1;
        endcase
        busy_d = (state_d != ON) && (state_d != OFF);
        on_d   = (state_d == ON);
        done_d = (state_d != state_q) && ((state_d == ON) || (state_d == OFF));
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= BOOT_RST;
            ret_q     <= 1'b0;
            err_q     <= 1'b0;
            clkgate_q <= 1'b0;
            switch_q  <= 1'b0;
            iso_q     <= 1'b0;
            rst_q     <= 1'b0;
            ram_q     <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            on_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            err_q     <= err_d;
            clkgate_q <= clkgate_d;
            switch_q  <= switch_d;
            iso_q     <= iso_d;
            rst_q     <= rst_d;
            ram_q     <= ram_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            on_q      <= on_d;
        end
    end

    assign clkgate_en_no    = clkgate_q;
    assign switch_no        = switch_q;
    assign iso_no           = iso_q;
    assign subsys_rst_no    = rst_q;
    assign ram_retentive_no = ram_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign is_on_o          = on_q;
    assign error_o          = err_q;

endmodule

// File: tb/tb_cgra_power_sequencer.sv
// Scoreboard bench: stimulus queues each expected output change with its
// cycle; a monitor compares whenever the registered outputs change.
module tb_cgra_power_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic on_req = 1'b0, off_req = 1'b0, ret_req = 1'b0;
    logic cgra_idle = 1'b1;
    logic ack_stuck = 1'b0;
    logic [1:0] ack_pipe = 2'b00;
    logic switch_ack_n;
    logic clkgate_en_n, switch_n, iso_n, subsys_rst_n, ram_ret_n;
    logic busy, done, is_on, error;

    always #5 clk = ~clk;

    cgra_power_sequencer #(
        .ISO_WAIT   (4),
        .RST_WAIT   (4),
        .ACK_TIMEOUT(8)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .on_req_i        (on_req),
        .off_req_i       (off_req),
        .retentive_req_i (ret_req),
        .cgra_idle_i     (cgra_idle),
        .switch_ack_ni   (switch_ack_n),
        .clkgate_en_no   (clkgate_en_n),
        .switch_no       (switch_n),
        .iso_no          (iso_n),
        .subsys_rst_no   (subsys_rst_n),
        .ram_retentive_no(ram_ret_n),
        .busy_o          (busy),
        .done_o          (done),
        .is_on_o         (is_on),
        .error_o         (error)
    );

    // Power-switch model: ack follows switch_no through two flops, so the
    // DUT first sees the new level on the third edge after switch_no moves.
    always @(posedge clk) ack_pipe <= {ack_pipe[0], switch_n};
    assign switch_ack_n = ack_stuck ? 1'b1 : ack_pipe[1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {clkgate, switch, iso, rst, ram, busy, done, is_on, error}
    wire [8:0] out_vec = {clkgate_en_n, switch_n, iso_n, subsys_rst_n, ram_ret_n,
                          busy, done, is_on, error};

    localparam logic [8:0] RSTV    = 9'b0_0_0_0_1_1_0_0_0;
    localparam logic [8:0] ISOV    = 9'b0_0_0_1_1_1_0_0_0;
    localparam logic [8:0] ONDN    = 9'b0_0_1_1_1_0_1_1_0;
    localparam logic [8:0] ONV     = 9'b0_0_1_1_1_0_0_1_0;
    localparam logic [8:0] OFFIDLE = 9'b0_0_1_1_1_1_0_0_0;
    localparam logic [8:0] SWN     = 9'b1_1_0_0_1_1_0_0_0;
    localparam logic [8:0] SWR     = 9'b1_1_0_0_0_1_0_0_0;
    localparam logic [8:0] OFFDN   = 9'b1_1_0_0_1_0_1_0_0;
    localparam logic [8:0] OFFV    = 9'b1_1_0_0_1_0_0_0_0;
    localparam logic [8:0] OFFDNR  = 9'b1_1_0_0_0_0_1_0_0;
    localparam logic [8:0] OFFVR   = 9'b1_1_0_0_0_0_0_0_0;
    localparam logic [8:0] ONSW    = 9'b1_0_0_0_1_1_0_0_0;
    localparam logic [8:0] ONSWR   = 9'b1_0_0_0_0_1_0_0_0;
    localparam logic [8:0] TODN    = 9'b1_1_0_0_1_0_1_0_1;
    localparam logic [8:0] TOV     = 9'b1_1_0_0_1_0_0_0_1;

    typedef struct {
        string      tag;
        int         at;
        logic [8:0] vec;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   probe_cnt = 0;
    int   probe_seen = 0;
    event probe_ev;
    logic [8:0] prev_vec = 9'b0;
    bit   mon_init = 1'b0;

    task automatic score(input logic [8:0] cur, input bit is_probe);
        exp_t it;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected: outputs %b at cycle %0d, no change expected", cur, cyc);
        end else begin
            it = sb.pop_front();
            if (cur !== it.vec || (!is_probe && it.at != cyc)) begin
                n_fail++;
                $display("FAIL %s: got %b at cycle %0d, expected %b at cycle %0d",
                         it.tag, cur, cyc, it.vec, it.at);
            end
        end
    endtask

    // Monitor: score on output change or explicit probe; retire overdue items.
    always @(negedge clk or probe_ev) begin : monitor
        logic [8:0] cur;
        cur = out_vec;
        if (probe_cnt != probe_seen) begin
            probe_seen = probe_cnt;
            score(cur, 1'b1);
        end else if (mon_init && cur !== prev_vec) begin
            score(cur, 1'b0);
        end else if (sb.size() != 0 && sb[0].at >= 0 && sb[0].at < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no change seen, expected %b at cycle %0d (now %0d)",
                     sb[0].tag, sb[0].vec, sb[0].at, cyc);
            sb.delete(0);
        end
        prev_vec = cur;
        mon_init = 1'b1;
    end

    task automatic expect_at(input string tag, input int at, input logic [8:0] v);
        exp_t it;
        it.tag = tag;
        it.at  = at;
        it.vec = v;
        sb.push_back(it);
    endtask

    task automatic probe(input string tag, input logic [8:0] v);
        expect_at(tag, -1, v);
        probe_cnt++;
        -> probe_ev;
    endtask

    task automatic issue(input logic on, input logic off, input logic ret, output int e);
        @(negedge clk);
        on_req  = on;
        off_req = off;
        ret_req = ret;
        e = cyc + 1;
    endtask

    task automatic release_req();
        @(negedge clk);
        on_req  = 1'b0;
        off_req = 1'b0;
        ret_req = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d expectations still pending", sb.size());
            $fatal(1, "scoreboard stuck");
        end
    endtask

    task automatic boot();
        int r;
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        expect_at("boot_rst_release", r + 4, ISOV);
        expect_at("boot_on_done",     r + 5, ONDN);
        expect_at("boot_on",          r + 6, ONV);
        drain();
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 probe(tag, RSTV);
        #1;
    endtask

    task automatic power_up(input int b, input bit retained);
        expect_at("up_switch_on",  b,     retained ? ONSWR : ONSW);
        expect_at("up_clk_ungate", b + 3, RSTV);
        expect_at("up_rst_release", b + 7, ISOV);
        expect_at("up_on_done",    b + 8, ONDN);
        expect_at("up_on",         b + 9, ONV);
    endtask

    initial begin
        int e;
        repeat (3) @(negedge clk);
        probe("reset_values", RSTV);
        boot();
        repeat (2) @(negedge clk);

        // on_req while ON must be ignored
        issue(1'b1, 1'b0, 1'b0, e);
        release_req();
        repeat (4) @(negedge clk);

        // Power-down with a busy CGRA for 10 cycles
        cgra_idle = 1'b0;
        issue(1'b0, 1'b1, 1'b0, e);
        expect_at("off_idle_wait", e,      OFFIDLE);
        expect_at("off_iso",       e + 10, ISOV);
        expect_at("off_switch",    e + 14, SWN);
        expect_at("off_done",      e + 17, OFFDN);
        expect_at("off_state",     e + 18, OFFV);
        release_req();
        repeat (9) @(negedge clk);
        cgra_idle = 1'b1;
        drain();

        issue(1'b1, 1'b0, 1'b0, e);
        power_up(e, 1'b0);
        release_req();
        drain();

        // Both requests in ON with retention; off_req during OFF_ISO ignored
        issue(1'b1, 1'b1, 1'b1, e);
        expect_at("ret_idle",   e,     OFFIDLE);
        expect_at("ret_iso",    e + 1, ISOV);
        expect_at("ret_switch", e + 5, SWR);
        expect_at("ret_done",   e + 8, OFFDNR);
        expect_at("ret_off",    e + 9, OFFVR);
        release_req();
        @(negedge clk);
        issue(1'b0, 1'b1, 1'b0, e);
        release_req();
        drain();
        repeat (3) @(negedge clk);
        issue(1'b1, 1'b0, 1'b0, e);
        power_up(e, 1'b1);
        release_req();
        drain();

        // Plain power-down, then power-up against a stuck ack
        issue(1'b0, 1'b1, 1'b0, e);
        expect_at("off2_idle",   e,     OFFIDLE);
        expect_at("off2_iso",    e + 1, ISOV);
        expect_at("off2_switch", e + 5, SWN);
        expect_at("off2_done",   e + 8, OFFDN);
        expect_at("off2_off",    e + 9, OFFV);
        release_req();
        drain();
        ack_stuck = 1'b1;
        issue(1'b1, 1'b0, 1'b0, e);
        expect_at("to_switch_on", e,      ONSW);
        expect_at("to_error",     e + 9,  TODN);
        expect_at("to_off",       e + 10, TOV);
        release_req();
        drain();

        // Next on_req clears error; reset lands in ON_RST
        ack_stuck = 1'b0;
        repeat (2) @(negedge clk);
        issue(1'b1, 1'b0, 1'b0, e);
        expect_at("clr_switch_on", e,     ONSW);
        expect_at("clr_clk_ungate", e + 3, RSTV);
        release_req();
        repeat (3) @(negedge clk);
        async_reset("reset_in_on_rst");
        boot();

        repeat (2) @(negedge clk);
        async_reset("reset_from_on");
        drain();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
